nco_quad_lut: RTL and testbench

- Parametrised numerically controlled oscillator producing two's-complement sine/cosine pairs for the DDC mixer path.
- Successor to the fixed 24-bit/14-bit NCO: accumulator, output and LUT widths are parameters.
- Adds over the fixed NCO: registered increment load (frequency hop), phase-offset input, synchronous accumulator clear, and an internal quarter-wave ROM with exact quadrant folding.
- Output pipeline of 3 clken-qualified stages.

---
 rtl/nco_quad_lut.sv | 92 +++++++++
 tb/tb_nco_quad_lut.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/nco_quad_lut.sv
// Quadrature NCO: phase accumulator with loadable increment and phase offset,
// a quarter-wave sine ROM with exact quadrant folding, and 3 clken-qualified output stages.
module nco_quad_lut #(
  parameter int                 PHASE_W  = 24,
  parameter int                 OUT_W    = 14,
  parameter int                 LUT_AW   = 10,
  parameter logic [PHASE_W-1:0] INC_INIT = '0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clken,
  input  logic [PHASE_W-1:0] phi_inc_i,
  input  logic               phi_inc_ld,
  input  logic [PHASE_W-1:0] phase_ofs_i,
  input  logic               acc_clr,
  output logic [OUT_W-1:0]   fsin_o,
  output logic [OUT_W-1:0]   fcos_o,
  output logic               out_valid
);

  localparam int ROM_N    = 2**LUT_AW;
  localparam int PH_W     = LUT_AW + 2;
  localparam int PH_SHIFT = PHASE_W - PH_W;

  // Entries are sampled at half-step offsets so that rom[~a] is the exact
  // cosine partner of rom[a]; this makes the quadrant folding symmetric.
  function automatic logic [OUT_W-1:0] rom_val(input int k);
    real amp;
    real ang;
    amp = real'((2**(OUT_W-1)) - 1);
    ang = (real'(k) + 0.5) * 3.14159265358979323846 / real'(2**(LUT_AW+1));
    return OUT_W'($rtoi(amp * $sin(ang) + 0.5));
  endfunction

  logic [OUT_W-1:0] rom [ROM_N];

  for (genvar k = 0; k < ROM_N; k++) begin : g_rom
    localparam logic [OUT_W-1:0] ENTRY = rom_val(k);
    assign rom[k] = ENTRY;
  end

  logic [PHASE_W-1:0] acc_q, acc_d;
  logic [PHASE_W-1:0] inc_q;
  logic [PH_W-1:0]    ph_q, ph_d;
  logic [OUT_W-1:0]   rs_q, rc_q;
  logic [1:0]         quad_q;
  logic [OUT_W-1:0]   sin_q, sin_d, cos_q, cos_d;
  logic [2:0]         vld_q;

  always_comb begin
    acc_d = acc_clr ? '0 : acc_q + inc_q;
    // only the quadrant and ROM address bits of the offset phase are kept
    ph_d  = PH_W'((acc_q + phase_ofs_i) >> PH_SHIFT);
    sin_d = rs_q;
    cos_d = rc_q;
    case (quad_q)
      2'd1:    begin sin_d = rc_q;  cos_d = -rs_q; end
      2'd2:    begin sin_d = -rs_q; cos_d = -rc_q; end
      2'd3:    begin sin_d = -rc_q; cos_d = rs_q;  end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q  <= '0;
      inc_q  <= INC_INIT;
      ph_q   <= '0;
      rs_q   <= '0;
      rc_q   <= '0;
      quad_q <= '0;
      sin_q  <= '0;
      cos_q  <= '0;
      vld_q  <= '0;
    end else if (clken) begin
      acc_q <= acc_d;
      if (phi_inc_ld) inc_q <= phi_inc_i;
      ph_q   <= ph_d;
      rs_q   <= rom[ph_q[LUT_AW-1:0]];
      rc_q   <= rom[~ph_q[LUT_AW-1:0]];
      quad_q <= ph_q[PH_W-1 -: 2];
      sin_q  <= sin_d;
      cos_q  <= cos_d;
      vld_q  <= {vld_q[1:0], 1'b1};
    end
  end

  assign fsin_o    = sin_q;
  assign fcos_o    = cos_q;
  assign out_valid = vld_q[2];

endmodule

// File: tb/tb_nco_quad_lut.sv
// Directed bench for nco_quad_lut: a cycle model pushes the expected sin/cos per
// enabled edge into a queue and pops it when the sample reaches the output.
module tb_nco_quad_lut;

  localparam real PI = 3.14159265358979323846;

  typedef struct packed {
    logic [13:0] s;
    logic [13:0] c;
  } sc_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clken;
  logic [23:0] phi_inc_i;
  logic        phi_inc_ld;
  logic [23:0] phase_ofs_i;
  logic        acc_clr;
  logic [13:0] fsin_o;
  logic [13:0] fcos_o;
  logic        out_valid;

  nco_quad_lut dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clken      (clken),
    .phi_inc_i  (phi_inc_i),
    .phi_inc_ld (phi_inc_ld),
    .phase_ofs_i(phase_ofs_i),
    .acc_clr    (acc_clr),
    .fsin_o     (fsin_o),
    .fcos_o     (fcos_o),
    .out_valid  (out_valid)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  sc_t         sb_q[$];
  logic [23:0] m_acc;
  logic [23:0] m_inc;
  logic [2:0]  m_vld;
  sc_t         exp_o;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(-x + 0.5);
  endfunction

  // ideal sample at the centre of the 4096-step phase bin
  function automatic sc_t calc(input logic [23:0] ph);
    sc_t r;
    real th;
    th  = 2.0 * PI * (real'(ph[23:12]) + 0.5) / 4096.0;
    r.s = 14'(rnd(8191.0 * $sin(th)));
    r.c = 14'(rnd(8191.0 * $cos(th)));
    return r;
  endfunction

  task automatic model_reset();
    m_acc = '0;
    m_inc = '0;
    m_vld = '0;
    exp_o = '0;
    sb_q.delete();
  endtask

  task automatic step(input bit en, input bit ld, input logic [23:0] inc_v,
                      input logic [23:0] ofs_v, input bit clr);
    clken       = en;
    phi_inc_ld  = ld;
    phi_inc_i   = inc_v;
    phase_ofs_i = ofs_v;
    acc_clr     = clr;
    @(posedge clk);
    #1;
    if (en) begin
      sb_q.push_back(calc(m_acc + ofs_v));
      m_acc = clr ? 24'd0 : m_acc + m_inc;
      if (ld) m_inc = inc_v;
      m_vld = {m_vld[1:0], 1'b1};
      if (sb_q.size() == 3) exp_o = sb_q.pop_front();
    end
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_vld[2]});
    chk("acc", {8'd0, dut.acc_q}, {8'd0, m_acc});
    if (m_vld[2]) begin
      chk("fsin", $signed(fsin_o), $signed(exp_o.s));
      chk("fcos", $signed(fcos_o), $signed(exp_o.c));
    end
  endtask

  int lit_s[6] = '{6, 6, 8191, -6, -8191, 6};
  int lit_c[6] = '{8191, 8191, -6, -8191, 6, 8191};

  initial begin
    reset_n     = 1'b0;
    clken       = 1'b0;
    phi_inc_i   = '0;
    phi_inc_ld  = 1'b0;
    phase_ofs_i = '0;
    acc_clr     = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fsin", $signed(fsin_o), 0);
    chk("rst_fcos", $signed(fcos_o), 0);
    chk("rst_valid", {31'd0, out_valid}, 0);
    reset_n = 1'b1;

    // quarter-turn stream; increment loaded on the first edge
    step(1, 1, 24'h400000, 24'h0, 0);
    for (int i = 0; i < 7; i++) begin
      step(1, 0, 24'h0, 24'h0, 0);
      if (i >= 1) begin
        chk("tp_sin", $signed(fsin_o), lit_s[i-1]);
        chk("tp_cos", $signed(fcos_o), lit_c[i-1]);
      end
    end

    // half-turn phase offset enters at S1
    for (int i = 0; i < 6; i++) step(1, 0, 24'h0, 24'h800000, 0);

    // frequency hop from 2^22 to 2^21
    step(1, 1, 24'h200000, 24'h0, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 24'h0, 24'h0, 0);

    // clear together with load of -1: negative-frequency rotation through the wrap
    step(1, 1, 24'hFFFFFF, 24'h0, 1);
    for (int i = 0; i < 10; i++) step(1, 0, 24'h0, 24'h0, 0);

    // clock-enable stalls
    step(1, 1, 24'h0C0000, 24'h0, 0);
    step(1, 0, 24'h0, 24'h0, 0);
    step(0, 1, 24'h123456, 24'h0, 1);
    step(0, 0, 24'h0, 24'h0, 1);
    step(1, 0, 24'h0, 24'h0, 0);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1)
        step(1, 0, 24'h0, 24'($urandom_range(0, 32'h00FFFFFF)), 0);
      else
        step(0, 1'($urandom_range(0, 1)), 24'($urandom_range(0, 32'h00FFFFFF)),
             24'($urandom_range(0, 32'h00FFFFFF)), 1'($urandom_range(0, 1)));
    end

    // asynchronous reset in the middle of a cycle with clear and load active
    clken      = 1'b1;
    acc_clr    = 1'b1;
    phi_inc_ld = 1'b1;
    phi_inc_i  = 24'h123456;
    #3 reset_n = 1'b0;
    #1;
    chk("arst_fsin", $signed(fsin_o), 0);
    chk("arst_fcos", $signed(fcos_o), 0);
    chk("arst_valid", {31'd0, out_valid}, 0);
    @(posedge clk);
    #1;
    chk("arst_hold_valid", {31'd0, out_valid}, 0);
    chk("arst_hold_fsin", $signed(fsin_o), 0);
    chk("arst_inc", {8'd0, dut.inc_q}, 0);
    model_reset();
    reset_n    = 1'b1;
    acc_clr    = 1'b0;
    phi_inc_ld = 1'b0;
    for (int i = 0; i < 4; i++) step(1, 0, 24'h0, 24'h0, 0);
    chk("post_rst_inc", {8'd0, dut.inc_q}, 0);
    step(1, 1, 24'h155555, 24'h0, 0);
    for (int i = 0; i < 8; i++) step(1, 0, 24'h0, 24'h030000, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
